// File: rtl/l1_meta_pkg.sv
// Shared definitions for the L1 metadata array: coherence encodings, FSM states,
// and default-width request/entry types for clients.
package l1_meta_pkg;

  localparam int unsigned DEF_N_SETS   = 64;
  localparam int unsigned DEF_N_WAYS   = 4;
  localparam int unsigned DEF_TAG_BITS = 20;
  localparam int unsigned DEF_COH_BITS = 2;
  localparam int unsigned DEF_IDX_BITS = $clog2(DEF_N_SETS);

  typedef enum logic [DEF_COH_BITS-1:0] {
    NOTHING = 2'd0,
    BRANCH  = 2'd1,
    TRUNK   = 2'd2,
    DIRTY   = 2'd3
  } coh_e;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } meta_state_e;

  typedef struct packed {
    logic [DEF_TAG_BITS-1:0] tag;
    coh_e                    coh;
  } meta_entry_t;

  typedef struct packed {
    logic [DEF_IDX_BITS-1:0] idx;
    logic [DEF_TAG_BITS-1:0] tag;
  } meta_read_req_t;

  typedef struct packed {
    logic [DEF_IDX_BITS-1:0] idx;
    logic [DEF_N_WAYS-1:0]   way_en;
    logic [DEF_TAG_BITS-1:0] tag;
    coh_e                    coh;
  } meta_write_req_t;

endpackage

// File: rtl/l1_meta_way.sv
// One way of the metadata array: N_SETS x {coh, tag} storage with a single
// write port and a registered synchronous read port.
module l1_meta_way #(
  parameter  int unsigned N_SETS   = 64,
  parameter  int unsigned TAG_BITS = 20,
  parameter  int unsigned COH_BITS = 2,
  localparam int unsigned IDX_W    = $clog2(N_SETS)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_we,
  input  logic [IDX_W-1:0]    i_widx,
  input  logic [TAG_BITS-1:0] i_wtag,
  input  logic [COH_BITS-1:0] i_wcoh,
  input  logic                i_re,
  input  logic [IDX_W-1:0]    i_ridx,
  output logic [TAG_BITS-1:0] o_rtag,
  output logic [COH_BITS-1:0] o_rcoh
);

  logic [COH_BITS+TAG_BITS-1:0] r_mem [N_SETS];
  logic [COH_BITS+TAG_BITS-1:0] r_rd;

  // Storage itself has no reset; the INIT sweep clears it.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_widx] <= {i_wcoh, i_wtag};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)     r_rd <= '0;
    else if (i_re) r_rd <= r_mem[i_ridx];
  end

  assign o_rtag = r_rd[TAG_BITS-1:0];
  assign o_rcoh = r_rd[COH_BITS+TAG_BITS-1:TAG_BITS];

endmodule

// File: rtl/l1_meta_array.sv
// L1 data-cache tag/coherence array: INIT clear sweep, write-priority arbitration,
// 1-cycle registered read with per-way hit. Optional flush via L1_META_FLUSH_EN.
module l1_meta_array
  import l1_meta_pkg::*;
#(
  parameter  int unsigned N_SETS   = 64,
  parameter  int unsigned N_WAYS   = 4,
  parameter  int unsigned TAG_BITS = 20,
  parameter  int unsigned COH_BITS = 2,
  localparam int unsigned IDX_W    = $clog2(N_SETS)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         read_valid,
  output logic                         read_ready,
  input  logic [IDX_W-1:0]             read_idx,
  input  logic [TAG_BITS-1:0]          read_tag,
  output logic                         resp_valid,
  output logic [N_WAYS*TAG_BITS-1:0]   resp_tag,
  output logic [N_WAYS*COH_BITS-1:0]   resp_coh,
  output logic [N_WAYS-1:0]            resp_hit_way,
  output logic                         resp_hit,
  input  logic                         write_valid,
  output logic                         write_ready,
  input  logic [IDX_W-1:0]             write_idx,
  input  logic [N_WAYS-1:0]            write_way_en,
  input  logic [TAG_BITS-1:0]          write_tag,
  input  logic [COH_BITS-1:0]          write_coh,
  output logic                         init_done
`ifdef L1_META_FLUSH_EN
  ,
  input  logic                         flush_req,
  output logic                         flush_done
`endif
);

  localparam logic [IDX_W-1:0] LAST_SET = IDX_W'(N_SETS - 1);

  meta_state_e         r_state, w_next;
  logic [IDX_W-1:0]    r_cnt;
  logic [TAG_BITS-1:0] r_read_tag;
  logic                r_resp_valid;
  logic                w_init, w_ready, w_wr, w_rd;
  logic [IDX_W-1:0]    w_widx;
  logic [TAG_BITS-1:0] w_wtag;
  logic [COH_BITS-1:0] w_wcoh;
  logic [N_WAYS-1:0]   w_we;
  logic                w_flush;

`ifdef L1_META_FLUSH_EN
  assign w_flush = flush_req;
`else
  assign w_flush = 1'b0;
`endif

  assign w_init  = (r_state == ST_INIT);
  assign w_ready = (r_state == ST_READY);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_INIT:  if (r_cnt == LAST_SET) w_next = ST_READY;
      ST_READY: if (w_flush) w_next = ST_INIT;
      default:  w_next = ST_INIT;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_INIT;
    else       r_state <= w_next;
  end

  // Counter wraps to 0 on the last INIT set, so a later flush restarts at set 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)       r_cnt <= '0;
    else if (w_init) r_cnt <= r_cnt + 1'b1;
    else             r_cnt <= '0;
  end

  assign write_ready = w_ready;
  assign read_ready  = w_ready & ~write_valid;
  assign init_done   = w_ready;

  assign w_wr   = write_valid & write_ready;
  assign w_rd   = read_valid & read_ready;
  assign w_widx = w_init ? r_cnt : write_idx;
  assign w_wtag = w_init ? '0 : write_tag;
  assign w_wcoh = w_init ? '0 : write_coh;
  assign w_we   = w_init ? '1 : (w_wr ? write_way_en : '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_resp_valid <= 1'b0;
      r_read_tag   <= '0;
    end else begin
      r_resp_valid <= w_rd;
      if (w_rd) r_read_tag <= read_tag;
    end
  end

  assign resp_valid = r_resp_valid;

  for (genvar w = 0; w < N_WAYS; w++) begin : g_way
    logic [TAG_BITS-1:0] w_rtag;
    logic [COH_BITS-1:0] w_rcoh;

    l1_meta_way #(
      .N_SETS   (N_SETS),
      .TAG_BITS (TAG_BITS),
      .COH_BITS (COH_BITS)
    ) u_way (
      .i_clk  (clock),
      .i_rst  (reset),
      .i_we   (w_we[w]),
      .i_widx (w_widx),
      .i_wtag (w_wtag),
      .i_wcoh (w_wcoh),
      .i_re   (w_rd),
      .i_ridx (read_idx),
      .o_rtag (w_rtag),
      .o_rcoh (w_rcoh)
    );

    assign resp_tag[w*TAG_BITS +: TAG_BITS] = w_rtag;
    assign resp_coh[w*COH_BITS +: COH_BITS] = w_rcoh;
    assign resp_hit_way[w] = (w_rcoh != '0) && (w_rtag == r_read_tag);
  end

  assign resp_hit = |resp_hit_way;

`ifdef L1_META_FLUSH_EN
  logic r_flush_pend, r_flush_done;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_flush_pend <= 1'b0;
      r_flush_done <= 1'b0;
    end else begin
      r_flush_done <= 1'b0;
      if (w_ready && flush_req) begin
        r_flush_pend <= 1'b1;
      end else if (w_init && r_cnt == LAST_SET && r_flush_pend) begin
        r_flush_pend <= 1'b0;
        r_flush_done <= 1'b1;
      end
    end
  end

  assign flush_done = r_flush_done;
`endif

endmodule

// File: tb/tb_l1_meta_array.sv
// Directed scoreboard bench for l1_meta_array; flush steps build with L1_META_FLUSH_EN.
module tb_l1_meta_array;

  localparam int unsigned N_SETS   = 64;
  localparam int unsigned N_WAYS   = 4;
  localparam int unsigned TAG_BITS = 20;
  localparam int unsigned COH_BITS = 2;
  localparam int unsigned IDX_W    = $clog2(N_SETS);

  logic                       clock = 1'b0;
  logic                       reset = 1'b1;
  logic                       read_valid = 1'b0;
  logic                       read_ready;
  logic [IDX_W-1:0]           read_idx = '0;
  logic [TAG_BITS-1:0]        read_tag = '0;
  logic                       resp_valid;
  logic [N_WAYS*TAG_BITS-1:0] resp_tag;
  logic [N_WAYS*COH_BITS-1:0] resp_coh;
  logic [N_WAYS-1:0]          resp_hit_way;
  logic                       resp_hit;
  logic                       write_valid = 1'b0;
  logic                       write_ready;
  logic [IDX_W-1:0]           write_idx = '0;
  logic [N_WAYS-1:0]          write_way_en = '0;
  logic [TAG_BITS-1:0]        write_tag = '0;
  logic [COH_BITS-1:0]        write_coh = '0;
  logic                       init_done;
`ifdef L1_META_FLUSH_EN
  logic                       flush_req = 1'b0;
  logic                       flush_done;
`endif

  l1_meta_array #(
    .N_SETS   (N_SETS),
    .N_WAYS   (N_WAYS),
    .TAG_BITS (TAG_BITS),
    .COH_BITS (COH_BITS)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .read_valid   (read_valid),
    .read_ready   (read_ready),
    .read_idx     (read_idx),
    .read_tag     (read_tag),
    .resp_valid   (resp_valid),
    .resp_tag     (resp_tag),
    .resp_coh     (resp_coh),
    .resp_hit_way (resp_hit_way),
    .resp_hit     (resp_hit),
    .write_valid  (write_valid),
    .write_ready  (write_ready),
    .write_idx    (write_idx),
    .write_way_en (write_way_en),
    .write_tag    (write_tag),
    .write_coh    (write_coh),
    .init_done    (init_done)
`ifdef L1_META_FLUSH_EN
    ,
    .flush_req    (flush_req),
    .flush_done   (flush_done)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [N_WAYS*TAG_BITS-1:0] tag;
    logic [N_WAYS*COH_BITS-1:0] coh;
    logic [N_WAYS-1:0]          hw;
    int                         due;
  } exp_t;

  exp_t                q[$];
  logic [TAG_BITS-1:0] m_tag [N_SETS][N_WAYS];
  logic [COH_BITS-1:0] m_coh [N_SETS][N_WAYS];
  int                  ntests = 0;
  int                  nfail  = 0;
  int                  cyc    = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int s = 0; s < N_SETS; s++)
      for (int w = 0; w < N_WAYS; w++) begin
        m_tag[s][w] = '0;
        m_coh[s][w] = '0;
      end
  endtask

  task automatic push_exp(input int idx, input logic [TAG_BITS-1:0] tg);
    exp_t e;
    for (int w = 0; w < N_WAYS; w++) begin
      e.tag[w*TAG_BITS +: TAG_BITS] = m_tag[idx][w];
      e.coh[w*COH_BITS +: COH_BITS] = m_coh[idx][w];
      e.hw[w] = (m_coh[idx][w] != '0) && (m_tag[idx][w] == tg);
    end
    e.due = cyc + 1;
    q.push_back(e);
  endtask

  // Response monitor: pops the scoreboard on every resp_valid.
  always @(negedge clock) begin
    exp_t e;
    if (resp_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_resp", 1, 0);
      end else begin
        e = q.pop_front();
        chk("resp_latency", 128'(cyc), 128'(e.due));
        chk("resp_tag", resp_tag, e.tag);
        chk("resp_coh", resp_coh, e.coh);
        chk("resp_hit_way", resp_hit_way, e.hw);
        chk("resp_hit", resp_hit, |e.hw);
        chk("hit_onehot", $onehot0(resp_hit_way), 1);
      end
    end else if (q.size() > 0 && q[0].due <= cyc) begin
      chk("missing_resp", 0, 1);
      void'(q.pop_front());
    end
  end

  task automatic wait_init(input string tag);
    int n = 0;
    bit bad = 0;
    while (n < 200) begin
      @(posedge clock); #1;
      n++;
      if (init_done) break;
      if (read_ready || write_ready) bad = 1;
    end
    chk({tag, "_cycles"}, 128'(n), 128'(N_SETS));
    chk({tag, "_readies_low"}, 128'(bad), 0);
    chk({tag, "_write_ready"}, write_ready, 1);
  endtask

  task automatic do_write(input int idx, input logic [N_WAYS-1:0] en,
                          input logic [TAG_BITS-1:0] tg, input logic [COH_BITS-1:0] ch);
    int n = 0;
    write_valid = 1; write_idx = IDX_W'(idx); write_way_en = en;
    write_tag = tg; write_coh = ch;
    @(negedge clock);
    while (!write_ready && n < 20) begin n++; @(negedge clock); end
    chk("write_ready", write_ready, 1);
    @(posedge clock);
    if (write_ready)
      for (int w = 0; w < N_WAYS; w++)
        if (en[w]) begin m_tag[idx][w] = tg; m_coh[idx][w] = ch; end
    #1 write_valid = 0;
  endtask

  task automatic do_read(input int idx, input logic [TAG_BITS-1:0] tg, input bit keep);
    int n = 0;
    read_valid = 1; read_idx = IDX_W'(idx); read_tag = tg;
    @(negedge clock);
    while (!read_ready && n < 20) begin n++; @(negedge clock); end
    chk("read_ready", read_ready, 1);
    if (read_ready) push_exp(idx, tg);
    @(posedge clock); #1;
    if (!keep) read_valid = 0;
  endtask

  task automatic idle(input int n);
    read_valid = 0; write_valid = 0;
    repeat (n) begin @(posedge clock); #1; end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    clear_model();
    #1;
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_read_ready", read_ready, 0);
    chk("rst_write_ready", write_ready, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_resp_tag", resp_tag, 0);
    repeat (2) @(posedge clock);
    #1 reset = 0;
    wait_init("init");

    do_read(5, '0, 0);
    idle(2);

    do_write(3, 4'b0100, 20'h12345, 2'd2);
    do_read(3, 20'h12345, 0);
    do_read(3, 20'h54321, 0);
    do_write(3, 4'b0000, 20'hFFFFF, 2'd3);
    do_read(3, 20'h12345, 0);
    do_write(10, 4'b0011, 20'hABCDE, 2'd3);
    do_read(10, 20'h00001, 0);
    do_write(10, 4'b0001, 20'hABCDE, 2'd0);
    do_read(10, 20'hABCDE, 0);
    idle(2);

    // Simultaneous write and read: write wins, read follows and sees new data.
    write_valid = 1; write_idx = IDX_W'(20); write_way_en = 4'b0001;
    write_tag = 20'h55555; write_coh = 2'd1;
    read_valid = 1; read_idx = IDX_W'(20); read_tag = 20'h55555;
    @(negedge clock);
    chk("collide_read_ready", read_ready, 0);
    chk("collide_write_ready", write_ready, 1);
    @(posedge clock);
    m_tag[20][0] = 20'h55555; m_coh[20][0] = 2'd1;
    #1 write_valid = 0;
    @(negedge clock);
    chk("collide_read_ready_after", read_ready, 1);
    push_exp(20, 20'h55555);
    @(posedge clock); #1 read_valid = 0;
    idle(2);

    do_write(3, 4'b0100, 20'h12345, 2'd0);
    do_read(3, 20'h12345, 0);

    for (int i = 0; i < 4; i++) do_read(i * 3 + 1, 20'(i), 1);
    do_read(20, 20'h55555, 1);
    do_read(10, 20'hABCDE, 0);
    idle(2);

    do_write(3, 4'b1000, 20'h0BEEF, 2'd3);
    do_read(3, 20'h0BEEF, 0);
    reset = 1;
    q.delete();
    clear_model();
    #1;
    chk("abort_resp_valid", resp_valid, 0);
    chk("abort_resp_tag", resp_tag, 0);
    chk("abort_resp_coh", resp_coh, 0);
    chk("abort_init_done", init_done, 0);
    @(posedge clock); #1 reset = 0;
    wait_init("reinit");
    do_read(3, 20'h0BEEF, 1);
    do_read(10, 20'hABCDE, 1);
    do_read(20, 20'h55555, 1);
    do_read(N_SETS - 1, '0, 0);
    idle(2);

`ifdef L1_META_FLUSH_EN
    begin
      int n = 0;
      int pulses = 0;
      do_write(7, 4'b0010, 20'h77777, 2'd1);
      do_read(7, 20'h77777, 0);
      chk("flush_done_idle", flush_done, 0);
      flush_req = 1;
      @(posedge clock); #1 flush_req = 0;
      chk("flush_init_drop", init_done, 0);
      clear_model();
      while (n < 200) begin
        @(posedge clock); #1;
        n++;
        if (flush_done) pulses++;
        if (init_done) break;
      end
      chk("flush_init_cycles", 128'(n), 128'(N_SETS));
      repeat (3) begin @(posedge clock); #1; if (flush_done) pulses++; end
      chk("flush_done_pulses", 128'(pulses), 1);
      do_read(7, 20'h77777, 0);
      idle(2);
    end
`endif

    idle(3);
    chk("queue_drained", 128'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/l1_meta_array.md
# l1_meta_array

Parametrised L1 data-cache metadata array holding one {tag, coherence} entry per set per way. It serves indexed read requests with a 1-cycle registered response that includes per-way tag-match results. It accepts way-masked write requests and self-clears all entries after reset. It sits between the cache's request pipeline (reads) and the miss/probe handlers (writes).

## Interface
Parameters:
- N_SETS, 64, number of sets; power of two, ≥2
- N_WAYS, 4, associativity; ≥1
- TAG_BITS, 20, tag width
- COH_BITS, 2, coherence-state width; value 0 = Nothing (invalid)

Ports:
- clock  in  1  sole clock
- reset  in  1  asynchronous, active-high
- read_valid  in  1  read request
- read_ready  out  1  read accepted when both high
- read_idx  in  log2(N_SETS)  set index
- read_tag  in  TAG_BITS  tag to compare
- resp_valid  out  1  response strobe, single cycle
- resp_tag  out  N_WAYS*TAG_BITS  stored tags, way 0 in LSBs
- resp_coh  out  N_WAYS*COH_BITS  stored coherence states
- resp_hit_way  out  N_WAYS  per-way match
- resp_hit  out  1  OR of resp_hit_way
- write_valid  in  1  write request
- write_ready  out  1  write accepted when both high
- write_idx  in  log2(N_SETS)  set index
- write_way_en  in  N_WAYS  way mask
- write_tag  in  TAG_BITS  new tag
- write_coh  in  COH_BITS  new coherence state
- init_done  out  1  high once clearing completes

## Operation
- States: INIT, READY.
- Reset enters INIT with set counter 0. Reset asserted mid-operation does the same and aborts any in-flight response.
- INIT:
  - Each cycle, write tag=0 and coh=0 to all ways of the current set, then increment the counter.
  - After set N_SETS-1 is written, go to READY.
  - read_ready=0 and write_ready=0 throughout INIT.
- READY:
  - write_ready=1.
  - read_ready = !write_valid. Writes have priority; a read presented together with a write stalls.
- Write:
  - Update every way whose write_way_en bit is set.
  - write_way_en=0 is accepted and has no effect.
  - Multiple set bits write identical data to each selected way.
- Read:
  - Array is read synchronously. Outputs are registered on the cycle after the handshake.
  - resp_hit_way[w] = (coh[w] != 0) && (tag[w] == read_tag), using the read_tag captured at handshake.
  - Multiple hit bits are reported unmasked. The array does not enforce one-hot; the bench flags it as an error.
- Response:
  - resp_* payload holds its value until the next read handshake.
  - resp_valid is high for exactly one cycle. There is no backpressure.
- Reset values: read_ready=0, write_ready=0, resp_valid=0, all resp_* = 0, init_done=0.

## Timing
- INIT spans exactly N_SETS rising edges after reset deasserts; init_done and the readies go high after the N_SETS-th edge.
- Read latency is 1 cycle: a handshake at edge k gives resp_valid=1 between edges k and k+1.
- A write at edge k is visible to a read handshaken at edge k+1 or later.
- Back-to-back reads sustain 1 per cycle.

## Configuration
- L1_META_FLUSH_EN defined:
  - Adds ports flush_req (in, 1) and flush_done (out, 1, reset 0).
  - flush_req sampled high in READY returns the block to INIT. init_done drops in the next cycle.
  - On completion of that INIT, flush_done pulses high for 1 cycle.
  - flush_req during INIT is ignored.
- Undefined: flush ports are absent; INIT is entered only via reset.

## Structure
- Shared package l1_meta_pkg:
  - coherence encodings: NOTHING=0, BRANCH=1, TRUNK=2, DIRTY=3
  - default-width packed typedefs for the meta entry, read request and write request, used by clients
- Sub-module l1_meta_way: one per way, generated N_WAYS times. Each holds N_SETS×(TAG_BITS+COH_BITS) storage, a write enable and a sync read port. The top holds the FSM, counter, arbitration and hit logic.

## Test plan
- Reset, then N_SETS=64 → init_done rises after exactly 64 edges; readies low until then; reading idx 5 returns all coh=0, resp_hit=0.
- Write idx=3, way_en=4'b0100, tag=0x12345, coh=2; then read idx=3, tag=0x12345 → resp_hit_way=4'b0100, resp_hit=1, 1-cycle latency.
- write_valid and read_valid together → write accepted, read_ready=0 that cycle, read served the next cycle and sees the new data.
- Write coh=0 with matching tag → a later read gives resp_hit=0 despite tag equality.
- Reset asserted with resp pending → resp_valid=0 immediately; INIT restarts from set 0; all entries read back as 0.
- With L1_META_FLUSH_EN, flush_req after populating idx 7 → init_done low for 64 cycles; flush_done pulses once; idx 7 reads as coh=0.
